// File: rtl/perf_counter_bank_if.sv
// perf_counter_bank_if: event/control inputs, shadow read port and live-count outputs of perf_counter_bank
interface perf_counter_bank_if #(
   parameter int NUM_CH = 3,
   parameter int WIDTH  = 20,
   parameter int SELW   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
   logic                    global_en;
   logic [NUM_CH-1:0]       inc;
   logic [NUM_CH-1:0]       clear;
   logic                    snap_req;
   logic                    snap_done;
   logic                    rd_req;
   logic [SELW-1:0]         rd_sel;
   logic                    rd_valid;
   logic [WIDTH-1:0]        rd_data;
   logic                    rd_ovf;
   logic                    rd_err;
   logic [NUM_CH*WIDTH-1:0] live_cnt;
   logic [NUM_CH-1:0]       ovf;

   modport master (
      output global_en, inc, clear, snap_req, rd_req, rd_sel,
      input  snap_done, rd_valid, rd_data, rd_ovf, rd_err, live_cnt, ovf
   );
   modport slave (
      input  global_en, inc, clear, snap_req, rd_req, rd_sel,
      output snap_done, rd_valid, rd_data, rd_ovf, rd_err, live_cnt, ovf
   );
endinterface

// File: rtl/perf_counter_bank.sv
// perf_counter_bank: per-channel event counters with sticky overflow, atomic shadow snapshot and registered read port
module perf_counter_bank #(
   parameter int NUM_CH   = 3,
   parameter int WIDTH    = 20,
   parameter int SATURATE = 0,
   parameter int SELW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input logic                clk,
   input logic                reset,
   perf_counter_bank_if.slave bus
);
   logic [NUM_CH*WIDTH-1:0] r_cnt, r_shd, w_cnt_nxt;
   logic [NUM_CH-1:0]       r_ovf, r_sovf, w_ovf_nxt;
   logic [WIDTH-1:0]        r_rd_data, w_rd_data;
   logic                    r_rd_ovf, w_rd_ovf, w_rd_hit;
   logic                    r_rd_valid, r_rd_err, r_snap_done;

   always_comb begin
      w_cnt_nxt = r_cnt;
      w_ovf_nxt = r_ovf;
      for (int i = 0; i < NUM_CH; i++) begin
         if (bus.clear[i]) begin
            w_cnt_nxt[i*WIDTH +: WIDTH] = '0;
            w_ovf_nxt[i]                = 1'b0;
         end else if (bus.global_en && bus.inc[i]) begin
            if (&r_cnt[i*WIDTH +: WIDTH]) begin
               w_cnt_nxt[i*WIDTH +: WIDTH] = {WIDTH{SATURATE != 0}};
               w_ovf_nxt[i]                = 1'b1;
            end else begin
               w_cnt_nxt[i*WIDTH +: WIDTH] = r_cnt[i*WIDTH +: WIDTH] + WIDTH'(1);
            end
         end
      end
   end

   // Out-of-range selects match no channel and report as an error with zero data
   always_comb begin
      w_rd_data = '0;
      w_rd_ovf  = 1'b0;
      w_rd_hit  = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (bus.rd_sel == SELW'(i)) begin
            w_rd_data = r_shd[i*WIDTH +: WIDTH];
            w_rd_ovf  = r_sovf[i];
            w_rd_hit  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt       <= '0;
         r_ovf       <= '0;
         r_shd       <= '0;
         r_sovf      <= '0;
         r_snap_done <= 1'b0;
         r_rd_valid  <= 1'b0;
         r_rd_data   <= '0;
         r_rd_ovf    <= 1'b0;
         r_rd_err    <= 1'b0;
      end else begin
         r_cnt       <= w_cnt_nxt;
         r_ovf       <= w_ovf_nxt;
         r_snap_done <= bus.snap_req;
         r_rd_valid  <= bus.rd_req;
         if (bus.snap_req) begin
            r_shd  <= r_cnt;
            r_sovf <= r_ovf;
         end
         if (bus.rd_req) begin
            r_rd_data <= w_rd_data;
            r_rd_ovf  <= w_rd_ovf;
            r_rd_err  <= !w_rd_hit;
         end
      end
   end

   assign bus.live_cnt  = r_cnt;
   assign bus.ovf       = r_ovf;
   assign bus.snap_done = r_snap_done;
   assign bus.rd_valid  = r_rd_valid;
   assign bus.rd_data   = r_rd_data;
   assign bus.rd_ovf    = r_rd_ovf;
   assign bus.rd_err    = r_rd_err;
endmodule

// File: tb/tb_perf_counter_bank.sv
// tb_perf_counter_bank: directed checks of counting, wrap, saturate, snapshot/read and async reset
module tb_perf_counter_bank;
   logic clk   = 1'b0;
   logic reset = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   perf_counter_bank_if #(.NUM_CH(3), .WIDTH(20)) ifa ();
   perf_counter_bank_if #(.NUM_CH(3), .WIDTH(4))  ifw ();
   perf_counter_bank_if #(.NUM_CH(3), .WIDTH(4))  ifs ();

   perf_counter_bank #(.NUM_CH(3), .WIDTH(20), .SATURATE(0)) u_a (.clk(clk), .reset(reset), .bus(ifa.slave));
   perf_counter_bank #(.NUM_CH(3), .WIDTH(4),  .SATURATE(0)) u_w (.clk(clk), .reset(reset), .bus(ifw.slave));
   perf_counter_bank #(.NUM_CH(3), .WIDTH(4),  .SATURATE(1)) u_s (.clk(clk), .reset(reset), .bus(ifs.slave));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      ifa.global_en = 0; ifa.inc = 0; ifa.clear = 0; ifa.snap_req = 0; ifa.rd_req = 0; ifa.rd_sel = 0;
      ifw.global_en = 0; ifw.inc = 0; ifw.clear = 0; ifw.snap_req = 0; ifw.rd_req = 0; ifw.rd_sel = 0;
      ifs.global_en = 0; ifs.inc = 0; ifs.clear = 0; ifs.snap_req = 0; ifs.rd_req = 0; ifs.rd_sel = 0;
      #1 reset = 1'b1;
      #1;
      chk("rst_live", ifa.live_cnt, 0);
      chk("rst_ovf", ifa.ovf, 0);
      chk("rst_rd_valid", ifa.rd_valid, 0);
      chk("rst_snap_done", ifa.snap_done, 0);
      chk("rst_rd_err", ifa.rd_err, 0);
      chk("rst_sat_live", ifs.live_cnt, 0);
      @(negedge clk) reset = 1'b0;

      ifa.global_en = 1; ifa.inc = 3'b101;
      step(2);
      chk("basic_mid", ifa.live_cnt, {20'd2, 20'd0, 20'd2});
      ifa.inc = 3'b001;
      step(3);
      ifa.inc = 0;
      chk("basic_live", ifa.live_cnt, {20'd2, 20'd0, 20'd5});
      chk("basic_ovf", ifa.ovf, 0);

      ifw.global_en = 1; ifw.inc = 3'b010;
      step(15);
      chk("wrap_full", ifw.live_cnt, 12'h0F0);
      chk("wrap_full_ovf", ifw.ovf, 3'b000);
      step(1);
      chk("wrap_zero", ifw.live_cnt, 12'h000);
      chk("wrap_zero_ovf", ifw.ovf, 3'b010);
      step(1);
      chk("wrap_one", ifw.live_cnt, 12'h010);
      chk("wrap_one_ovf", ifw.ovf, 3'b010);
      ifw.inc = 0; ifw.snap_req = 1;
      step(1);
      ifw.snap_req = 0; ifw.rd_req = 1; ifw.rd_sel = 1;
      step(1);
      ifw.rd_req = 0;
      chk("wrap_rd_data", ifw.rd_data, 1);
      chk("wrap_rd_ovf", ifw.rd_ovf, 1);
      ifw.clear = 3'b010; ifw.inc = 3'b010;
      step(1);
      ifw.clear = 0; ifw.inc = 0;
      chk("wrap_clr_live", ifw.live_cnt, 0);
      chk("wrap_clr_ovf", ifw.ovf, 0);

      ifs.global_en = 1; ifs.inc = 3'b001;
      step(20);
      chk("sat_live", ifs.live_cnt, 12'h00F);
      chk("sat_ovf", ifs.ovf, 3'b001);
      step(3);
      ifs.inc = 0;
      chk("sat_hold", ifs.live_cnt, 12'h00F);

      ifa.clear = 3'b111;
      step(1);
      ifa.clear = 0;
      chk("snap_clr", ifa.live_cnt, 0);
      ifa.inc = 3'b111; step(3);
      ifa.inc = 3'b101; step(4);
      ifa.inc = 3'b100; step(2);
      chk("snap_pre", ifa.live_cnt, {20'd9, 20'd3, 20'd7});
      ifa.inc = 3'b111; ifa.snap_req = 1;
      step(1);
      chk("snap_done", ifa.snap_done, 1);
      chk("snap_live", ifa.live_cnt, {20'd10, 20'd4, 20'd8});
      ifa.snap_req = 0; ifa.rd_req = 1; ifa.rd_sel = 0;
      step(1);
      chk("snap_done_once", ifa.snap_done, 0);
      chk("rd0_valid", ifa.rd_valid, 1);
      chk("rd0_data", ifa.rd_data, 7);
      chk("rd0_err", ifa.rd_err, 0);
      ifa.rd_sel = 1;
      step(1);
      chk("rd1_data", ifa.rd_data, 3);
      ifa.rd_sel = 2;
      step(1);
      chk("rd2_data", ifa.rd_data, 9);
      chk("rd2_ovf", ifa.rd_ovf, 0);
      ifa.rd_sel = 3;
      step(1);
      chk("rd3_valid", ifa.rd_valid, 1);
      chk("rd3_err", ifa.rd_err, 1);
      chk("rd3_data", ifa.rd_data, 0);
      ifa.rd_req = 0; ifa.inc = 0;
      step(1);
      chk("rd_idle_valid", ifa.rd_valid, 0);
      chk("rd_idle_err_hold", ifa.rd_err, 1);
      chk("rd_live_after", ifa.live_cnt, {20'd14, 20'd8, 20'd12});

      ifa.clear = 3'b111;
      step(1);
      ifa.clear = 0; ifa.inc = 3'b001;
      step(4);
      ifa.inc = 0; ifa.snap_req = 1;
      step(1);
      ifa.snap_req = 0; ifa.inc = 3'b001;
      step(6);
      ifa.inc = 0;
      chk("same_live", ifa.live_cnt, 60'd10);
      ifa.snap_req = 1; ifa.rd_req = 1; ifa.rd_sel = 0;
      step(1);
      chk("same_rd_old", ifa.rd_data, 4);
      chk("same_snap_done", ifa.snap_done, 1);
      ifa.snap_req = 0;
      step(1);
      chk("same_rd_new", ifa.rd_data, 10);
      ifa.rd_req = 0; ifa.clear = 3'b001;
      step(1);
      ifa.clear = 0; ifa.rd_req = 1;
      step(1);
      ifa.rd_req = 0;
      chk("clr_keeps_shadow", ifa.rd_data, 10);
      chk("clr_live", ifa.live_cnt, 0);

      ifa.inc = 3'b111; ifa.rd_req = 1; ifa.snap_req = 1;
      step(2);
      chk("pre_rst_live", ifa.live_cnt, {20'd2, 20'd2, 20'd2});
      chk("pre_rst_valid", ifa.rd_valid, 1);
      #2 reset = 1'b1;
      #1;
      chk("async_live", ifa.live_cnt, 0);
      chk("async_valid", ifa.rd_valid, 0);
      chk("async_snap_done", ifa.snap_done, 0);
      ifa.inc = 0; ifa.rd_req = 0; ifa.snap_req = 0;
      @(negedge clk) reset = 1'b0;
      ifa.rd_req = 1; ifa.rd_sel = 0;
      step(1);
      ifa.rd_req = 0;
      chk("rst_shadow", ifa.rd_data, 0);
      ifa.inc = 3'b111;
      step(2);
      ifa.global_en = 0;
      step(3);
      chk("gen_freeze", ifa.live_cnt, {20'd2, 20'd2, 20'd2});
      ifa.clear = 3'b010;
      step(1);
      ifa.clear = 0; ifa.inc = 0;
      chk("gen_clear", ifa.live_cnt, {20'd2, 20'd0, 20'd2});

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
